// File: rtl/encrypt_config.sv
// Shared configuration for the encrypt/decrypt system: byte width, the
// decrypt output buffer's default sizing, and the common byte type.
package encrypt_config;

   localparam int BYTE_W            = 8;
   localparam int DEC_BUF_DEPTH     = 16;
   localparam int DEC_BUF_AF_THRESH = 12;

   typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/decrypt_output_buffer_mem.sv
// Storage for the decrypt output buffer: flop array with one synchronous
// write port and one asynchronous read port. Contents are not reset.
module decrypt_output_buffer_mem
   import encrypt_config::*;
#(
   parameter int DEPTH = DEC_BUF_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  byte_t         wr_data,
   input  logic [AW-1:0] rd_addr,
   output byte_t         rd_data
);

   byte_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/decrypt_output_buffer.sv
// FWFT buffer between the decrypt wrapper (no backpressure) and a valid/ready
// consumer; counts dropped bytes. Optional checksum: DECRYPT_BUF_CHECKSUM_EN.
module decrypt_output_buffer
   import encrypt_config::*;
#(
   parameter int DEPTH     = DEC_BUF_DEPTH,
   parameter int AF_THRESH = DEC_BUF_AF_THRESH,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  byte_t         in_data,
   output logic          out_valid,
   output byte_t         out_data,
   input  logic          out_ready,
   output logic [CW-1:0] count,
   output logic          almost_full,
   output logic          overflow,
   output logic [7:0]    drop_count,
   input  logic          clr_ovf
`ifdef DECRYPT_BUF_CHECKSUM_EN
   ,
   output byte_t         checksum,
   input  logic          clr_csum
`endif
);

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   byte_t         rd_data;
   logic          full;
   logic          push;
   logic          pop;
   logic          drop;

   // Full/empty come from count alone; a pop frees a slot for a same-cycle push.
   assign full        = (count == CW'(DEPTH));
   assign out_valid   = (count != '0);
   assign almost_full = (count >= CW'(AF_THRESH));
   assign pop         = out_valid & out_ready;
   assign push        = in_valid & (~full | pop);
   assign drop        = in_valid & full & ~pop;
   assign out_data    = out_valid ? rd_data : '0;

   decrypt_output_buffer_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wptr),
      .wr_data (in_data),
      .rd_addr (rptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Clear wins over a drop in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clr_ovf) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end

`ifdef DECRYPT_BUF_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           checksum <= '0;
      else if (clr_csum) checksum <= pop ? out_data : '0;
      else if (pop)      checksum <= checksum ^ out_data;
   end
`endif

endmodule

// File: tb/tb_decrypt_output_buffer.sv
// Self-checking bench for decrypt_output_buffer: hand-derived vector table,
// queue scoreboard and directed multi-cycle sequences.
module tb_decrypt_output_buffer;
   import encrypt_config::*;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   byte_t      in_data;
   logic       out_valid;
   byte_t      out_data;
   logic       out_ready;
   logic [4:0] count;
   logic       almost_full;
   logic       overflow;
   logic [7:0] drop_count;
   logic       clr_ovf;
`ifdef DECRYPT_BUF_CHECKSUM_EN
   byte_t      checksum;
   logic       clr_csum;
`endif

   int    nvec = 0;
   int    nmis = 0;
   byte_t q[$];
   logic  movf;
   int    mdrops;
   byte_t mcsum;

   always #5 clk = ~clk;

   decrypt_output_buffer #(.DEPTH(16), .AF_THRESH(12)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .count       (count),
      .almost_full (almost_full),
      .overflow    (overflow),
      .drop_count  (drop_count),
      .clr_ovf     (clr_ovf)
`ifdef DECRYPT_BUF_CHECKSUM_EN
      ,
      .checksum    (checksum),
      .clr_csum    (clr_csum)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("count", int'(count), q.size());
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("almost_full", int'(almost_full), int'(q.size() >= 12));
      chk("overflow", int'(overflow), int'(movf));
      chk("drop_count", int'(drop_count), mdrops);
      if (q.size() != 0) chk("head", int'(out_data), int'(q[0]));
`ifdef DECRYPT_BUF_CHECKSUM_EN
      chk("checksum", int'(checksum), int'(mcsum));
`endif
   endtask

   task automatic model_reset();
      q.delete();
      movf   = 1'b0;
      mdrops = 0;
      mcsum  = 8'h00;
   endtask

   // Drive one cycle from the falling edge, check, then advance the model.
   task automatic cycle(input logic iv, input byte_t d, input logic ordy, input logic clr);
      logic  pop;
      logic  push;
      logic  drop;
      logic  cc;
      byte_t exp;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      clr_ovf   = clr;
      cc        = 1'b0;
`ifdef DECRYPT_BUF_CHECKSUM_EN
      cc = clr_csum;
`endif
      #1;
      check_state();
      pop  = (q.size() != 0) && ordy;
      push = iv && ((q.size() < DEPTH) || pop);
      drop = iv && !push;
      exp  = 8'h00;
      if (pop) begin
         exp = q.pop_front();
         chk("pop_data", int'(out_data), int'(exp));
      end
      if (cc)       mcsum = pop ? exp : 8'h00;
      else if (pop) mcsum = mcsum ^ exp;
      @(posedge clk);
      if (push) q.push_back(d);
      if (clr) begin
         movf   = 1'b0;
         mdrops = 0;
      end else if (drop) begin
         movf = 1'b1;
         if (mdrops < 255) mdrops++;
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic  iv;
      byte_t d;
      logic  ordy;
      int    exp_count;
      logic  exp_valid;
      byte_t exp_data;
   } vec_t;

   vec_t tbl[10];

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
`ifdef DECRYPT_BUF_CHECKSUM_EN
      clr_csum  = 1'b0;
`endif
      model_reset();

      tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11};
      tbl[1] = '{1'b1, 8'h12, 1'b0, 2, 1'b1, 8'h11};
      tbl[2] = '{1'b1, 8'h13, 1'b0, 3, 1'b1, 8'h11};
      tbl[3] = '{1'b1, 8'h14, 1'b0, 4, 1'b1, 8'h11};
      tbl[4] = '{1'b1, 8'h15, 1'b0, 5, 1'b1, 8'h11};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 4, 1'b1, 8'h12};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 3, 1'b1, 8'h13};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h14};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h15};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_count", int'(count), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_drop_count", int'(drop_count), 0);
      rst = 1'b0;

      // Basic FWFT fill and drain
      foreach (tbl[i]) begin
         cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0);
         chk("tbl_count", int'(count), tbl[i].exp_count);
         chk("tbl_valid", int'(out_valid), int'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) chk("tbl_data", int'(out_data), int'(tbl[i].exp_data));
      end

      // Fill to full, almost_full threshold
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, byte_t'(8'h20 + i), 1'b0, 1'b0);
         chk("af_fill", int'(almost_full), int'(i >= 12));
      end
      chk("full_count", int'(count), 16);
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      #1;
      chk("ovf_set", int'(overflow), 1);
      chk("drops_3", int'(drop_count), 3);
      chk("ovf_head", int'(out_data), 8'h21);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      #1;
      chk("clr_ovf", int'(overflow), 0);
      chk("clr_drops", int'(drop_count), 0);

      // Saturation, then clear colliding with a drop
      for (int i = 0; i < 260; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      #1;
      chk("drops_sat", int'(drop_count), 255);
      cycle(1'b1, 8'hEE, 1'b0, 1'b1);
      #1;
      chk("clr_prio_ovf", int'(overflow), 0);
      chk("clr_prio_drops", int'(drop_count), 0);

      // Full with simultaneous push and pop across pointer wrap
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, byte_t'(8'h40 + i), 1'b1, 1'b0);
         chk("full_pp_count", int'(count), 16);
      end
      chk("full_pp_drops", int'(drop_count), 0);
      for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drained", int'(count), 0);

      // Empty with push and ready together: no bypass
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      #1;
      chk("nobypass_valid", int'(out_valid), 0);
      cycle(1'b1, 8'hA5, 1'b1, 1'b0);
      chk("bypass_next_data", int'(out_data), 8'hA5);
      chk("bypass_next_count", int'(count), 1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("bypass_drain", int'(count), 0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Asynchronous reset mid-operation
      for (int i = 0; i < 7; i++) cycle(1'b1, byte_t'(8'h60 + i), 1'b0, 1'b0);
      chk("pre_rst_count", int'(count), 7);
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_valid", int'(out_valid), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 8'h3C, 1'b0, 1'b0);
      chk("post_rst_head", int'(out_data), 8'h3C);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef DECRYPT_BUF_CHECKSUM_EN
      cycle(1'b1, 8'h0F, 1'b0, 1'b0);
      cycle(1'b1, 8'hF0, 1'b0, 1'b0);
      cycle(1'b1, 8'hFF, 1'b0, 1'b0);
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("csum_zero", int'(checksum), 8'h00);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("csum_5a", int'(checksum), 8'h5A);
      clr_csum = 1'b1;
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      clr_csum = 1'b0;
      chk("csum_clr", int'(checksum), 8'h00);
      cycle(1'b1, 8'h77, 1'b0, 1'b0);
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      clr_csum = 1'b1;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      clr_csum = 1'b0;
      chk("csum_clr_pop", int'(checksum), 8'h11);
`endif

      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
